// File: rtl/evm_pkg.sv
// Shared EVM definitions: ballot_unit state encoding, candidate codes and pulse bundle.
package evm_pkg;

   typedef enum logic [2:0] {
      ST_OFF     = 3'd0,
      ST_ARMED   = 3'd1,
      ST_ENABLED = 3'd2,
      ST_RELEASE = 3'd3,
      ST_CLOSED  = 3'd4
   } ballot_state_e;

   localparam int unsigned N_CAND = 3;

   // Candidate codes shared with the EVM core's candidate_name field
   localparam logic [1:0] CAND_NONE = 2'b00;
   localparam logic [1:0] CAND_1    = 2'b01;
   localparam logic [1:0] CAND_2    = 2'b10;
   localparam logic [1:0] CAND_3    = 2'b11;

   typedef struct packed {
      logic              candidate_ready;
      logic [N_CAND-1:0] vote;
      logic              multi_press_err;
      logic              timeout_err;
   } ballot_pulse_t;

   // One-hot candidate vector {c3,c2,c1} to code; anything not one-hot maps to CAND_NONE
   function automatic logic [1:0] cand_code(input logic [N_CAND-1:0] onehot);
      case (onehot)
         3'b001:  return CAND_1;
         3'b010:  return CAND_2;
         3'b100:  return CAND_3;
         default: return CAND_NONE;
      endcase
   endfunction

   function automatic logic [N_CAND-1:0] cand_onehot(input logic [1:0] code);
      case (code)
         CAND_1:  return 3'b001;
         CAND_2:  return 3'b010;
         CAND_3:  return 3'b100;
         default: return 3'b000;
      endcase
   endfunction

   function automatic logic cand_multi(input logic [N_CAND-1:0] lvl);
      return (lvl[0] & lvl[1]) | (lvl[0] & lvl[2]) | (lvl[1] & lvl[2]);
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a counting debouncer; rise_o pulses with the
// cycle the debounced level goes high.
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw_i,
   output logic level_o,
   output logic rise_o
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic [1:0]       sync_q;
   logic             level_q, level_d;
   logic             rise_q, rise_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Count consecutive disagreeing cycles; any agreement clears the count
   always_comb begin
      level_d = level_q;
      rise_d  = 1'b0;
      cnt_d   = '0;
      if (sync_q[1] != level_q) begin
         if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            level_d = sync_q[1];
            rise_d  = sync_q[1];
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync_q  <= {sync_q[0], btn_raw_i};
         level_q <= level_d;
         rise_q  <= rise_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level_o = level_q;
   assign rise_o  = rise_q;

endmodule

// File: rtl/ballot_unit.sv
// Ballot control front-end of the EVM: debounces officer/voter buttons and issues
// ballot and vote pulses. Define BALLOT_TIMEOUT_EN to withdraw idle ballots.
module ballot_unit
   import evm_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 8,
   parameter int unsigned TIMEOUT_CYCLES  = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic switch_on_evm,
   input  logic btn_ready,
   input  logic btn_done,
   input  logic btn_c1,
   input  logic btn_c2,
   input  logic btn_c3,
   output logic candidate_ready,
   output logic vote_candidate_1,
   output logic vote_candidate_2,
   output logic vote_candidate_3,
   output logic voting_session_done,
   output logic ballot_active,
   output logic multi_press_err,
   output logic timeout_err
);

`ifdef BALLOT_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   ballot_state_e     state_q, state_d;
   ballot_pulse_t     pulse_q, pulse_d;
   logic              done_q, active_q;
   logic              lock_q, lock_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic [1:0]        sw_sync_q;

   logic              ready_lvl, ready_rise, done_lvl, done_rise;
   logic [N_CAND-1:0] cand_lvl, cand_rise;
   logic [1:0]        rise_code_c;
   logic              tmo_hit_c;
   logic              unused_lvl;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ready (
      .clk(clk), .rst_n(rst), .btn_raw_i(btn_ready), .level_o(ready_lvl), .rise_o(ready_rise));
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_done (
      .clk(clk), .rst_n(rst), .btn_raw_i(btn_done), .level_o(done_lvl), .rise_o(done_rise));
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_c1 (
      .clk(clk), .rst_n(rst), .btn_raw_i(btn_c1), .level_o(cand_lvl[0]), .rise_o(cand_rise[0]));
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_c2 (
      .clk(clk), .rst_n(rst), .btn_raw_i(btn_c2), .level_o(cand_lvl[1]), .rise_o(cand_rise[1]));
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_c3 (
      .clk(clk), .rst_n(rst), .btn_raw_i(btn_c3), .level_o(cand_lvl[2]), .rise_o(cand_rise[2]));

   // Officer buttons act on edges only
   assign unused_lvl  = &{1'b0, ready_lvl, done_lvl};
   assign rise_code_c = cand_code(cand_rise);
   assign tmo_hit_c   = TMO_EN && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      state_d = state_q;
      pulse_d = '0;
      lock_d  = lock_q;
      tmo_d   = '0;
      unique case (state_q)
         ST_OFF: begin
            state_d = ST_ARMED;
         end
         ST_ARMED: begin
            if (done_rise) begin
               state_d = ST_CLOSED;
            end else if (ready_rise) begin
               state_d                 = ST_ENABLED;
               pulse_d.candidate_ready = 1'b1;
            end
         end
         ST_ENABLED: begin
            tmo_d = TMO_EN ? tmo_q + TMO_W'(1) : '0;
            // After a rejected multi-press, nothing counts until every candidate is released
            if (lock_q) begin
               if (cand_lvl == '0) lock_d = 1'b0;
            end else if (cand_multi(cand_lvl)) begin
               lock_d                  = 1'b1;
               pulse_d.multi_press_err = 1'b1;
            end else if (rise_code_c != CAND_NONE && cand_lvl == cand_rise) begin
               pulse_d.vote = cand_onehot(rise_code_c);
               state_d      = ST_RELEASE;
            end
            if (state_d == ST_ENABLED && tmo_hit_c) begin
               state_d             = ST_ARMED;
               pulse_d.timeout_err = 1'b1;
               lock_d              = 1'b0;
            end
         end
         ST_RELEASE: begin
            if (cand_lvl == '0) state_d = ST_ARMED;
         end
         ST_CLOSED: begin
            state_d = ST_CLOSED;
         end
         default: begin
            state_d = ST_OFF;
         end
      endcase
      // Power switch off overrides everything, including pulses about to issue
      if (!sw_sync_q[1]) begin
         state_d = ST_OFF;
         pulse_d = '0;
         lock_d  = 1'b0;
         tmo_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_OFF;
         pulse_q   <= '0;
         done_q    <= 1'b0;
         active_q  <= 1'b0;
         lock_q    <= 1'b0;
         tmo_q     <= '0;
         sw_sync_q <= '0;
      end else begin
         state_q   <= state_d;
         pulse_q   <= pulse_d;
         done_q    <= (state_d == ST_CLOSED);
         active_q  <= (state_d == ST_ENABLED);
         lock_q    <= lock_d;
         tmo_q     <= tmo_d;
         sw_sync_q <= {sw_sync_q[0], switch_on_evm};
      end
   end

   assign candidate_ready     = pulse_q.candidate_ready;
   assign vote_candidate_1    = pulse_q.vote[0];
   assign vote_candidate_2    = pulse_q.vote[1];
   assign vote_candidate_3    = pulse_q.vote[2];
   assign multi_press_err     = pulse_q.multi_press_err;
   assign timeout_err         = pulse_q.timeout_err;
   assign voting_session_done = done_q;
   assign ballot_active       = active_q;

endmodule

// File: tb/tb_ballot_unit.sv
// Directed self-checking bench for ballot_unit (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=20).
`timescale 1ns/1ps
module tb_ballot_unit;

   localparam int unsigned DEB = 4;
   localparam int unsigned TMO = 20;
   localparam int          LAT = DEB + 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic switch_on_evm = 1'b0;
   logic btn_ready = 1'b0, btn_done = 1'b0;
   logic btn_c1 = 1'b0, btn_c2 = 1'b0, btn_c3 = 1'b0;
   logic candidate_ready, vote_candidate_1, vote_candidate_2, vote_candidate_3;
   logic voting_session_done, ballot_active, multi_press_err, timeout_err;
   logic [7:0] outs;

   int n_cmp = 0;
   int n_bad = 0;
   int cnt [8] = '{default: 0};
   int overlap = 0;

   ballot_unit #(.DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst), .switch_on_evm(switch_on_evm),
      .btn_ready(btn_ready), .btn_done(btn_done),
      .btn_c1(btn_c1), .btn_c2(btn_c2), .btn_c3(btn_c3),
      .candidate_ready(candidate_ready),
      .vote_candidate_1(vote_candidate_1), .vote_candidate_2(vote_candidate_2),
      .vote_candidate_3(vote_candidate_3),
      .voting_session_done(voting_session_done), .ballot_active(ballot_active),
      .multi_press_err(multi_press_err), .timeout_err(timeout_err));

   // bit 0 ready, 1..3 votes, 4 done, 5 active, 6 multi err, 7 timeout
   assign outs = {timeout_err, multi_press_err, ballot_active, voting_session_done,
                  vote_candidate_3, vote_candidate_2, vote_candidate_1, candidate_ready};

   always #5 clk = ~clk;

   // Pulse tally, sampled 1ns after each rising edge
   always @(posedge clk) begin
      #1;
      for (int i = 0; i < 8; i++) if (outs[i] === 1'b1) cnt[i]++;
      if (candidate_ready && (vote_candidate_1 || vote_candidate_2 || vote_candidate_3)) overlap++;
      if (int'(vote_candidate_1) + int'(vote_candidate_2) + int'(vote_candidate_3) > 1) overlap++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_for(input int idx, input int bound, output int lat);
      lat = -1;
      for (int k = 1; k <= bound && lat < 0; k++) begin
         @(negedge clk);
         if (outs[idx] === 1'b1) lat = k;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int e_ready, e_v1, e_v2, e_v3, e_tmo;
      e_ready = 0; e_v1 = 0; e_v2 = 0; e_v3 = 0; e_tmo = 0;

      #2 rst = 1'b0;
      tick(3);
      chk("reset_outs", outs, 0);
      rst = 1'b1;
      tick(3);
      chk("off_outs", outs, 0);
      switch_on_evm = 1'b1;
      tick(4);
      chk("armed_idle", outs, 0);

      // Ballot with candidate 2 held 10 cycles
      btn_ready = 1'b1;
      wait_for(0, 20, lat); chk("ready_lat", lat, LAT); e_ready++;
      btn_ready = 1'b0;
      tick(1);
      chk("active_enabled", ballot_active, 1);
      btn_c2 = 1'b1;
      wait_for(2, 20, lat); chk("c2_lat", lat, LAT); e_v2++;
      tick(1);
      chk("c2_pulse_width", vote_candidate_2, 0);
      chk("active_after_vote", ballot_active, 0);
      tick(2); btn_c2 = 1'b0;
      tick(10);
      chk("cnt_ready_1", cnt[0], e_ready);
      chk("cnt_v2_1", cnt[2], e_v2);
      chk("cnt_v1v3_0", cnt[1] + cnt[3], 0);

      // Bouncy candidate 1 press
      btn_ready = 1'b1;
      wait_for(0, 20, lat); chk("ready2_lat", lat, LAT); e_ready++;
      btn_ready = 1'b0;
      btn_c1 = 1'b1; tick(1); btn_c1 = 1'b0; tick(1);
      btn_c1 = 1'b1; tick(1); btn_c1 = 1'b0; tick(1);
      btn_c1 = 1'b1; tick(10); btn_c1 = 1'b0; tick(10);
      e_v1++;
      chk("bounce_v1_once", cnt[1], e_v1);
      chk("bounce_active_low", ballot_active, 0);

      // Simultaneous c1+c3, then a clean c3
      btn_ready = 1'b1;
      wait_for(0, 20, lat); chk("ready3_lat", lat, LAT); e_ready++;
      btn_ready = 1'b0;
      btn_c1 = 1'b1; btn_c3 = 1'b1;
      tick(6);
      btn_c1 = 1'b0; btn_c3 = 1'b0;
      tick(5);
      chk("multi_err_once", cnt[6], 1);
      chk("multi_no_vote", cnt[1] + cnt[2] + cnt[3], e_v1 + e_v2 + e_v3);
      chk("multi_still_active", ballot_active, 1);
      btn_c3 = 1'b1;
      wait_for(3, 20, lat); chk("c3_lat", lat, LAT); e_v3++;
      tick(3); btn_c3 = 1'b0; tick(10);
      chk("cnt_v3_1", cnt[3], e_v3);

      // Idle ballot: withdrawn with the timeout feature, kept open without it
      btn_ready = 1'b1;
      wait_for(0, 20, lat); chk("ready4_lat", lat, LAT); e_ready++;
      btn_ready = 1'b0;
`ifdef BALLOT_TIMEOUT_EN
      wait_for(7, 40, lat); chk("tmo_lat", lat, TMO); e_tmo++;
      tick(1);
      chk("active_after_tmo", ballot_active, 0);
      btn_ready = 1'b1;
      wait_for(0, 20, lat); chk("ready_after_tmo", lat, LAT); e_ready++;
      btn_ready = 1'b0;
`else
      tick(30);
      chk("no_tmo_pulse", cnt[7], 0);
      chk("active_no_tmo", ballot_active, 1);
`endif
      btn_c1 = 1'b1;
      wait_for(1, 20, lat); chk("c1_lat", lat, LAT); e_v1++;
      tick(3); btn_c1 = 1'b0; tick(10);

      // Ready and done together: done wins, session closes
      btn_ready = 1'b1; btn_done = 1'b1;
      wait_for(4, 20, lat); chk("done_lat", lat, LAT);
      tick(2);
      chk("done_beats_ready", cnt[0], e_ready);
      chk("closed_not_active", ballot_active, 0);
      btn_ready = 1'b0; btn_done = 1'b0;
      tick(6);
      btn_c1 = 1'b1; tick(10); btn_c1 = 1'b0;
      btn_ready = 1'b1; tick(10); btn_ready = 1'b0; tick(8);
      chk("closed_done_held", voting_session_done, 1);
      chk("closed_no_vote", cnt[1], e_v1);
      chk("closed_no_ready", cnt[0], e_ready);
      switch_on_evm = 1'b0;
      tick(2);
      chk("done_before_off", voting_session_done, 1);
      tick(1);
      chk("switch_off_outs", outs, 0);

      // Reset in the middle of a candidate debounce
      switch_on_evm = 1'b1;
      tick(4);
      btn_ready = 1'b1;
      wait_for(0, 20, lat); chk("ready5_lat", lat, LAT); e_ready++;
      btn_ready = 1'b0;
      btn_c1 = 1'b1;
      tick(2);
      rst = 1'b0;
      #1;
      chk("rst_outs", outs, 0);
      tick(1);
      switch_on_evm = 1'b0;
      btn_c1 = 1'b0;
      tick(3);
      rst = 1'b1;
      tick(15);
      chk("rst_no_vote", cnt[1], e_v1);
      chk("post_rst_outs", outs, 0);

      chk("no_overlap", overlap, 0);
      chk("total_ready", cnt[0], e_ready);
      chk("total_v2", cnt[2], e_v2);
      chk("total_v3", cnt[3], e_v3);
      chk("total_multi", cnt[6], 1);
      chk("total_tmo", cnt[7], e_tmo);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
